// File: rtl/redmule_offload_sequencer.sv
// redmule_offload_sequencer
//   XIF offload decoder for RedMulE. Decodes MCNFIG / MARITH / CSR offloads,
//   queues complete job descriptors in a small FIFO and replays each job as
//   NumCfgRegs periph writes followed by a trigger write.
//
// Ports
//   clk_i, rst_i, clear_i     clock, sync active-high reset, soft clear (same effect)
//   issue_*                   XIF issue handshake, instruction and rs1..rs3 operands
//   result_ready_i/valid_o    XIF result; valid simply mirrors ready
//   periph_req_o/gnt_i        periph write request (write-only, wen=0, be='1, id=0)
//   periph_add_o/data_o       periph write address / data
//   cfg_complete_i            engine finished latching config (gates the trigger write)
//   start_cfg_o               pulse on the grant of the last cfg write
//   job_count_o, busy_o       queued jobs (including the active one), activity flag
//
// Optional feature: define REDMULE_OFFLOAD_PERF_CNT_EN to add the saturating
// perf_jobs_o / perf_stall_o counters.

module redmule_offload_sequencer #(
  parameter int unsigned SysDataWidth = 32,
  parameter int unsigned NumCfgRegs   = 6,
  parameter int unsigned JobDepth     = 2,
  parameter logic [31:0] CfgBaseAddr  = 32'h40,
  parameter logic [31:0] TriggerAddr  = 32'h00,
  parameter logic [11:0] CsrLo        = 12'h7C0,
  parameter logic [11:0] CsrHi        = 12'h7C0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clear_i,
  input  logic                              issue_valid_i,
  output logic                              issue_ready_o,
  output logic                              issue_accept_o,
  input  logic [31:0]                       issue_instr_i,
  input  logic                              issue_rs_valid_i,
  input  logic [2:0][SysDataWidth-1:0]      issue_rs_i,
  input  logic                              result_ready_i,
  output logic                              result_valid_o,
  output logic                              periph_req_o,
  input  logic                              periph_gnt_i,
  output logic [31:0]                       periph_add_o,
  output logic [SysDataWidth-1:0]           periph_data_o,
  input  logic                              cfg_complete_i,
  output logic                              start_cfg_o,
  output logic [$clog2(JobDepth+1)-1:0]     job_count_o,
  output logic                              busy_o
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_jobs_o,
  output logic [31:0]                       perf_stall_o
`endif
);

  localparam int unsigned CntW  = $clog2(JobDepth + 1);
  localparam int unsigned OffsW = (NumCfgRegs > 1) ? $clog2(NumCfgRegs) : 1;
  localparam int unsigned PtrW  = (JobDepth > 1) ? $clog2(JobDepth) : 1;

  localparam logic [6:0] OpcMcnfig = 7'b0001011;
  localparam logic [6:0] OpcMarith = 7'b0101011;
  localparam logic [6:0] OpcCsr    = 7'b1110011;

  typedef enum logic [1:0] {StIdle, StWriteCfg, StTrigger} state_e;

  // Job layout: 0..2 X/W/Z ptrs, 3 {K,M}, 4 N, 5 arith instruction.
  typedef logic [NumCfgRegs-1:0][SysDataWidth-1:0] job_t;

  state_e                  state_q;
  logic [OffsW-1:0]        reg_offs_q;
  logic [CntW-1:0]         count_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [SysDataWidth-1:0] shadow_km_q, shadow_n_q;
  job_t                    fifo_q [JobDepth];

  logic       sync_clr;
  logic       full;
  logic [6:0] opcode;
  logic [11:0] csr_addr;
  logic       push, cfg_upd;
  logic       cfg_gnt, trig_gnt, cfg_last;

  assign sync_clr = rst_i | clear_i;
  assign opcode   = issue_instr_i[6:0];
  assign csr_addr = issue_instr_i[31:20];
  // Full is judged on the pre-pop count, so a pop never frees a slot in the same cycle.
  assign full     = (count_q == CntW'(JobDepth));

  always_comb begin
    issue_ready_o  = 1'b0;
    issue_accept_o = 1'b0;
    push           = 1'b0;
    cfg_upd        = 1'b0;
    if (issue_valid_i && !sync_clr) begin
      case (opcode)
        OpcMcnfig: begin
          issue_ready_o  = 1'b1;
          issue_accept_o = 1'b1;
          cfg_upd        = issue_rs_valid_i;
        end
        OpcMarith: begin
          if (issue_rs_valid_i && !full) begin
            issue_ready_o  = 1'b1;
            issue_accept_o = 1'b1;
            push           = 1'b1;
          end
        end
        OpcCsr: begin
          issue_ready_o  = 1'b1;
          issue_accept_o = (csr_addr >= CsrLo) && (csr_addr <= CsrHi);
        end
        default: ;
      endcase
    end
  end

  assign result_valid_o = result_ready_i;

  assign cfg_last = (reg_offs_q == OffsW'(NumCfgRegs - 1));
  assign cfg_gnt  = (state_q == StWriteCfg) && periph_gnt_i;
  assign trig_gnt = (state_q == StTrigger) && cfg_complete_i && periph_gnt_i;

  always_comb begin
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_data_o = '0;
    case (state_q)
      StWriteCfg: begin
        periph_req_o  = 1'b1;
        periph_add_o  = CfgBaseAddr + 32'({reg_offs_q, 2'b00});
        periph_data_o = fifo_q[rd_ptr_q][reg_offs_q];
      end
      StTrigger: begin
        periph_req_o = cfg_complete_i;
        periph_add_o = TriggerAddr;
      end
      default: ;
    endcase
  end

  assign start_cfg_o = cfg_gnt && cfg_last && !sync_clr;
  assign job_count_o = count_q;
  assign busy_o      = (state_q != StIdle) || (count_q != '0);

`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
  logic [31:0] perf_jobs_q, perf_stall_q;
  logic        stall;
  assign stall        = issue_valid_i && (opcode == OpcMarith) && full;
  assign perf_jobs_o  = perf_jobs_q;
  assign perf_stall_o = perf_stall_q;
`endif

  always_ff @(posedge clk_i) begin
    if (sync_clr) begin
      state_q     <= StIdle;
      reg_offs_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      shadow_km_q <= '0;
      shadow_n_q  <= '0;
      for (int unsigned i = 0; i < JobDepth; i++) fifo_q[i] <= '0;
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
      perf_jobs_q  <= '0;
      perf_stall_q <= '0;
`endif
    end else begin
      if (cfg_upd) begin
        shadow_km_q <= issue_rs_i[0];
        shadow_n_q  <= issue_rs_i[1];
      end

      // Snapshot the shadow regs so later MCNFIGs leave queued jobs untouched.
      if (push) begin
        fifo_q[wr_ptr_q][0] <= issue_rs_i[0];
        fifo_q[wr_ptr_q][1] <= issue_rs_i[1];
        fifo_q[wr_ptr_q][2] <= issue_rs_i[2];
        fifo_q[wr_ptr_q][3] <= shadow_km_q;
        fifo_q[wr_ptr_q][4] <= shadow_n_q;
        fifo_q[wr_ptr_q][5] <= SysDataWidth'(issue_instr_i);
        wr_ptr_q <= (wr_ptr_q == PtrW'(JobDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end

      if (trig_gnt) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(JobDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end

      case ({push, trig_gnt})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase

      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q    <= StWriteCfg;
            reg_offs_q <= '0;
          end
        end
        StWriteCfg: begin
          if (cfg_gnt) begin
            if (cfg_last) begin
              reg_offs_q <= '0;
              state_q    <= StTrigger;
            end else begin
              reg_offs_q <= reg_offs_q + OffsW'(1);
            end
          end
        end
        StTrigger: begin
          // Chain straight into the next queued job without an idle cycle.
          if (trig_gnt) state_q <= (count_q > CntW'(1)) ? StWriteCfg : StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
      if (trig_gnt && (perf_jobs_q != '1)) perf_jobs_q <= perf_jobs_q + 32'd1;
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
`endif
    end
  end

endmodule

// File: tb/tb_redmule_offload_sequencer.sv
// Testbench for redmule_offload_sequencer: directed steps followed by a random
// phase, all checked against a queue-based model of the expected periph writes.

module tb_redmule_offload_sequencer;

  localparam int unsigned JobDepth = 2;
  localparam logic [6:0] OpcMcnfig = 7'b0001011;
  localparam logic [6:0] OpcMarith = 7'b0101011;
  localparam logic [6:0] OpcCsr    = 7'b1110011;

  logic            clk = 1'b0;
  logic            rst_i, clear_i;
  logic            issue_valid_i, issue_ready_o, issue_accept_o;
  logic [31:0]     issue_instr_i;
  logic            issue_rs_valid_i;
  logic [2:0][31:0] issue_rs_i;
  logic            result_ready_i, result_valid_o;
  logic            periph_req_o, periph_gnt_i;
  logic [31:0]     periph_add_o, periph_data_o;
  logic            cfg_complete_i, start_cfg_o;
  logic [1:0]      job_count_o;
  logic            busy_o;
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
  logic [31:0]     perf_jobs_o, perf_stall_o;
`endif

  redmule_offload_sequencer #(.JobDepth(JobDepth)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_accept_o(issue_accept_o), .issue_instr_i(issue_instr_i),
    .issue_rs_valid_i(issue_rs_valid_i), .issue_rs_i(issue_rs_i),
    .result_ready_i(result_ready_i), .result_valid_o(result_valid_o),
    .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i),
    .periph_add_o(periph_add_o), .periph_data_o(periph_data_o),
    .cfg_complete_i(cfg_complete_i), .start_cfg_o(start_cfg_o),
    .job_count_o(job_count_o), .busy_o(busy_o)
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
    , .perf_jobs_o(perf_jobs_o), .perf_stall_o(perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  // One expected periph write; idx 0..5 are cfg regs, 6 is the trigger.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
  } wr_t;

  wr_t         expq[$];
  int          mcount;
  logic [31:0] sh_km, sh_n;
  logic [31:0] m_jobs, m_stall;
  int          total, bad;
  int          cyc, first_gnt_cyc, trig_gnt_cyc, accept_cyc, start_pulses;
  bit          exp_req_next, last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle at the falling edge, then advances the model across
  // the rising edge. Returns 1 time unit after that edge, ready for new inputs.
  task automatic cycle();
    bit   rst_now, push, grant, next_exp;
    logic exp_rdy, exp_acc;
    int   pre_count;
    wr_t  f;
    @(negedge clk);
    rst_now = rst_i | clear_i;
    push    = 0;
    grant   = 0;
    chk("result_valid", result_valid_o, result_ready_i);
    if (!rst_now) begin
      chk("job_count", job_count_o, mcount);
      chk("busy", busy_o, mcount != 0);
      exp_rdy = 0;
      exp_acc = 0;
      if (issue_valid_i) begin
        case (issue_instr_i[6:0])
          OpcMcnfig: begin exp_rdy = 1; exp_acc = 1; end
          OpcMarith: if (issue_rs_valid_i && mcount < JobDepth) begin
            exp_rdy = 1; exp_acc = 1; push = 1;
          end
          OpcCsr: begin
            exp_rdy = 1;
            exp_acc = (issue_instr_i[31:20] == 12'h7C0);
          end
          default: ;
        endcase
        chk("issue_ready", issue_ready_o, exp_rdy);
      end
      chk("issue_accept", issue_accept_o, exp_acc);
      if (expq.size() == 0) begin
        chk("req_idle", periph_req_o, 0);
      end else begin
        f = expq[0];
        if (f.idx == 6 && !cfg_complete_i) chk("req_trig_wait", periph_req_o, 0);
        else if (exp_req_next) chk("req_continue", periph_req_o, 1);
        if (periph_req_o) begin
          chk("periph_add", periph_add_o, f.addr);
          chk("periph_data", periph_data_o, f.data);
        end
        grant = periph_req_o && periph_gnt_i;
      end
      chk("start_cfg", start_cfg_o, grant && expq[0].idx == 5);
      if (start_cfg_o) start_pulses++;
    end
    pre_count = mcount;
    @(posedge clk);
    if (rst_now) begin
      expq.delete();
      mcount = 0; sh_km = 0; sh_n = 0; m_jobs = 0; m_stall = 0;
      exp_req_next = 0; last_push = 0;
    end else begin
      next_exp = 0;
      if (grant) begin
        f = expq.pop_front();
        if (f.idx == 0) first_gnt_cyc = cyc;
        if (f.idx == 6) begin
          trig_gnt_cyc = cyc;
          mcount--;
          if (m_jobs != 32'hFFFF_FFFF) m_jobs++;
          next_exp = (pre_count > 1);
        end else begin
          next_exp = 1;
        end
      end else if (periph_req_o && expq.size() != 0 && expq[0].idx != 6) begin
        next_exp = 1;
      end
      if (issue_valid_i && issue_instr_i[6:0] == OpcMarith && pre_count == JobDepth &&
          m_stall != 32'hFFFF_FFFF) m_stall++;
      if (push) begin
        logic [31:0] job [6];
        job[0] = issue_rs_i[0]; job[1] = issue_rs_i[1]; job[2] = issue_rs_i[2];
        job[3] = sh_km; job[4] = sh_n; job[5] = issue_instr_i;
        for (int i = 0; i < 6; i++) expq.push_back('{32'h40 + 32'(4 * i), job[i], i});
        expq.push_back('{32'h0, 32'h0, 6});
        mcount++;
        accept_cyc = cyc;
      end
      last_push = push;
      if (issue_valid_i && issue_instr_i[6:0] == OpcMcnfig && issue_rs_valid_i) begin
        sh_km = issue_rs_i[0];
        sh_n  = issue_rs_i[1];
      end
      exp_req_next = next_exp;
    end
    cyc++;
    #1;
  endtask

  task automatic set_issue(input logic [6:0] opc, input logic [24:0] upper,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
    issue_valid_i    = 1;
    issue_rs_valid_i = 1;
    issue_instr_i    = {upper, opc};
    issue_rs_i[0]    = r1;
    issue_rs_i[1]    = r2;
    issue_rs_i[2]    = r3;
  endtask

  task automatic drain(input string tag);
    issue_valid_i  = 0;
    periph_gnt_i   = 1;
    cfg_complete_i = 1;
    for (int i = 0; i < 200 && expq.size() != 0; i++) cycle();
    chk(tag, expq.size(), 0);
  endtask

  task automatic do_reset();
    rst_i = 1;
    cycle();
    rst_i = 0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mcount = 0; start_pulses = 0;
    sh_km = 0; sh_n = 0; m_jobs = 0; m_stall = 0; exp_req_next = 0; last_push = 0;
    first_gnt_cyc = 0; trig_gnt_cyc = 0; accept_cyc = 0;
    rst_i = 1; clear_i = 0; issue_valid_i = 0; issue_instr_i = 0; issue_rs_valid_i = 0;
    issue_rs_i = '0; result_ready_i = 1; periph_gnt_i = 0; cfg_complete_i = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst_i = 0;
    #1;
    chk("reset_req", periph_req_o, 0);
    chk("reset_count", job_count_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_start", start_cfg_o, 0);
    chk("reset_add", periph_add_o, 0);
    result_ready_i = 0;
    cycle();
    result_ready_i = 1;

    // Decode of CSR window and unknown opcodes.
    set_issue(OpcCsr, {12'h7C0, 13'h0}, 0, 0, 0);
    #1; chk("csr_lo_ready", issue_ready_o, 1); chk("csr_lo_accept", issue_accept_o, 1);
    cycle();
    set_issue(OpcCsr, {12'h300, 13'h0}, 0, 0, 0);
    #1; chk("csr_300_ready", issue_ready_o, 1); chk("csr_300_accept", issue_accept_o, 0);
    cycle();
    set_issue(7'h33, 25'h0, 0, 0, 0);
    #1; chk("opc33_ready", issue_ready_o, 0); chk("opc33_accept", issue_accept_o, 0);
    cycle();
    issue_valid_i = 0;
    cycle();

    // Single job: cfg writes in order, then trigger, back-to-back with gnt always 1.
    periph_gnt_i = 1; cfg_complete_i = 1; start_pulses = 0;
    set_issue(OpcMcnfig, 25'h0, 32'h0020_0010, 32'h40, 0);
    cycle();
    set_issue(OpcMarith, 25'h0AB_CDE, 32'h100, 32'h200, 32'h300);
    cycle();
    issue_valid_i = 0;
    for (int i = 0; i < 30 && expq.size() != 0; i++) cycle();
    chk("job1_drained", expq.size(), 0);
    chk("job1_latency", trig_gnt_cyc - first_gnt_cyc, 6);
    chk("job1_start_pulses", start_pulses, 1);

    // Reset in the middle of WriteCfg with three cfg writes already granted.
    set_issue(OpcMarith, 25'h1, 32'h11, 32'h22, 32'h33);
    cycle();
    issue_valid_i = 0;
    for (int i = 0; i < 20 && !(expq.size() != 0 && expq[0].idx == 3); i++) cycle();
    chk("mid_reached", (expq.size() != 0) ? expq[0].idx : -1, 3);
    do_reset();
    #1;
    chk("mid_rst_req", periph_req_o, 0);
    chk("mid_rst_count", job_count_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    cycle();

    // Two jobs queued, then four cycles of a third MARITH held off by a full FIFO.
    periph_gnt_i = 0;
    for (int j = 0; j < 3; j++) begin
      set_issue(OpcMarith, 25'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    chk("full_count", job_count_o, 2);
    for (int j = 0; j < 3; j++) begin
      #1; chk("full_ready", issue_ready_o, 0);
      cycle();
    end
    drain("perf_drain");
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
    chk("perf_jobs_2", perf_jobs_o, 2);
    chk("perf_stall_4", perf_stall_o, 4);
`endif

    // Third MARITH is accepted the cycle after the first trigger grant.
    periph_gnt_i = 0;
    for (int j = 0; j < 3; j++) begin
      set_issue(OpcMarith, 25'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    #1; chk("third_stalled", issue_ready_o, 0);
    periph_gnt_i = 1; cfg_complete_i = 1;
    last_push = 0;
    for (int i = 0; i < 40 && !last_push; i++) cycle();
    chk("third_accepted", last_push, 1);
    chk("third_accept_cyc", accept_cyc - trig_gnt_cyc, 1);
    drain("third_drain");

    // Trigger held off by cfg_complete_i, next job follows the trigger grant directly.
    cfg_complete_i = 0;
    for (int j = 0; j < 2; j++) begin
      set_issue(OpcMarith, 25'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    issue_valid_i = 0;
    for (int i = 0; i < 20 && !(expq.size() != 0 && expq[0].idx == 6); i++) cycle();
    chk("trig_reached", (expq.size() != 0) ? expq[0].idx : -1, 6);
    for (int j = 0; j < 5; j++) begin
      #1; chk("trig_hold_req", periph_req_o, 0);
      cycle();
    end
    cfg_complete_i = 1;
    #1; chk("trig_req", periph_req_o, 1); chk("trig_add", periph_add_o, 32'h0);
    cycle();
    #1; chk("next_job_req", periph_req_o, 1); chk("next_job_add", periph_add_o, 32'h40);
    drain("trig_drain");

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      int sel;
      sel = $urandom_range(0, 3);
      issue_valid_i    = ($urandom_range(0, 2) != 0);
      issue_rs_valid_i = ($urandom_range(0, 4) != 0);
      issue_rs_i[0]    = $urandom;
      issue_rs_i[1]    = $urandom;
      issue_rs_i[2]    = $urandom;
      issue_instr_i    = $urandom;
      case (sel)
        0: issue_instr_i[6:0] = OpcMcnfig;
        1: issue_instr_i[6:0] = OpcMarith;
        2: begin
          issue_instr_i[6:0] = OpcCsr;
          case ($urandom_range(0, 3))
            0: issue_instr_i[31:20] = 12'h7C0;
            1: issue_instr_i[31:20] = 12'h7C1;
            2: issue_instr_i[31:20] = 12'h7BF;
            default: ;
          endcase
        end
        default: issue_instr_i[6:0] = 7'h33;
      endcase
      periph_gnt_i   = ($urandom_range(0, 2) != 0);
      cfg_complete_i = ($urandom_range(0, 3) != 0);
      result_ready_i = $urandom_range(0, 1);
      clear_i        = ($urandom_range(0, 99) == 0);
      cycle();
    end
    clear_i = 0;
    drain("rand_drain");
    cycle();
`ifdef REDMULE_OFFLOAD_PERF_CNT_EN
    chk("perf_jobs_rand", perf_jobs_o, m_jobs);
    chk("perf_stall_rand", perf_stall_o, m_stall);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
